// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction-memory request/ready bus between the fetch stage and imem
//
// Ports (modports):
//   master (fetch stage): drives imem_req, imem_addr; receives imem_data, imem_ready
//   slave  (memory)     : receives imem_req, imem_addr; drives imem_data, imem_ready
// A transfer completes on any cycle where imem_req and imem_ready are both high.
interface fetch_stage_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    logic                  imem_req;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [DATA_WIDTH-1:0] imem_data;
    logic                  imem_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_data,
        input  imem_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_data,
        output imem_ready
    );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage and IF/ID pipeline register with skid buffer and redirect discard
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   branching_so_flush  redirect request from the ID branch unit
//   branch_target       redirect address, valid with branching_so_flush
//   stall               hazard unit request to hold IF/ID
//   imem                instruction-memory bus (master side)
//   instr_id            IF/ID instruction
//   pc_plus_id          IF/ID address of the fetched instruction + PC_INC
//   valid_id            IF/ID holds a real instruction
module fetch_stage #(
    parameter int                     PC_WIDTH    = 16,
    parameter int                     INSTR_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
    parameter logic [PC_WIDTH-1:0]    PC_INC      = 1,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   branching_so_flush,
    input  logic [PC_WIDTH-1:0]    branch_target,
    input  logic                   stall,
    fetch_stage_if.master          imem,
    output logic [INSTR_WIDTH-1:0] instr_id,
    output logic [PC_WIDTH-1:0]    pc_plus_id,
    output logic                   valid_id
);

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t                 state, state_n;
    logic [PC_WIDTH-1:0]    fetch_pc, fetch_pc_n;
    logic [PC_WIDTH-1:0]    redirect_pc, redirect_pc_n;
    logic [INSTR_WIDTH-1:0] skid_instr, skid_instr_n;
    logic [PC_WIDTH-1:0]    skid_pc_plus, skid_pc_plus_n;
    logic                   skid_valid, skid_valid_n;
    logic [INSTR_WIDTH-1:0] instr_id_n;
    logic [PC_WIDTH-1:0]    pc_plus_id_n;
    logic                   valid_id_n;

    logic                   req;
    logic                   complete;
    logic [PC_WIDTH-1:0]    pc_next;

    // A held skid entry stops new requests so at most one fetched-but-unconsumed
    // instruction exists; DISCARD keeps requesting to retire the in-flight fetch.
    assign req      = (state == FETCH && !skid_valid) || state == DISCARD;
    assign complete = req && imem.imem_ready;
    assign pc_next  = fetch_pc + PC_INC;

    assign imem.imem_req  = req;
    assign imem.imem_addr = fetch_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= BOOT;
            fetch_pc     <= RESET_PC;
            redirect_pc  <= '0;
            skid_instr   <= NOP_INSTR;
            skid_pc_plus <= '0;
            skid_valid   <= 1'b0;
            instr_id     <= NOP_INSTR;
            pc_plus_id   <= '0;
            valid_id     <= 1'b0;
        end else begin
            state        <= state_n;
            fetch_pc     <= fetch_pc_n;
            redirect_pc  <= redirect_pc_n;
            skid_instr   <= skid_instr_n;
            skid_pc_plus <= skid_pc_plus_n;
            skid_valid   <= skid_valid_n;
            instr_id     <= instr_id_n;
            pc_plus_id   <= pc_plus_id_n;
            valid_id     <= valid_id_n;
        end
    end

    always_comb begin
        state_n        = state;
        fetch_pc_n     = fetch_pc;
        redirect_pc_n  = redirect_pc;
        skid_instr_n   = skid_instr;
        skid_pc_plus_n = skid_pc_plus;
        skid_valid_n   = skid_valid;
        instr_id_n     = instr_id;
        pc_plus_id_n   = pc_plus_id;
        valid_id_n     = valid_id;

        if (branching_so_flush) begin
            instr_id_n   = NOP_INSTR;
            valid_id_n   = 1'b0;
            skid_valid_n = 1'b0;
            unique case (state)
                BOOT: begin
                    fetch_pc_n = branch_target;
                    state_n    = FETCH;
                end
                FETCH: begin
                    if (complete) begin
                        fetch_pc_n = branch_target;
                    end else if (req) begin
                        // Memory still owes a response for fetch_pc; it must be
                        // absorbed before the new address can be presented.
                        redirect_pc_n = branch_target;
                        state_n       = DISCARD;
                    end else begin
                        fetch_pc_n = branch_target;
                    end
                end
                DISCARD: begin
                    redirect_pc_n = branch_target;
                    if (complete) begin
                        fetch_pc_n = branch_target;
                        state_n    = FETCH;
                    end
                end
                default: state_n = BOOT;
            endcase
        end else begin
            unique case (state)
                BOOT: begin
                    state_n = FETCH;
                end
                DISCARD: begin
                    if (complete) begin
                        fetch_pc_n = redirect_pc;
                        state_n    = FETCH;
                    end
                end
                FETCH: begin
                    if (complete) begin
                        fetch_pc_n = pc_next;
                        if (!stall) begin
                            instr_id_n   = imem.imem_data;
                            pc_plus_id_n = pc_next;
                            valid_id_n   = 1'b1;
                        end else begin
                            skid_instr_n   = imem.imem_data;
                            skid_pc_plus_n = pc_next;
                            skid_valid_n   = 1'b1;
                        end
                    end else if (skid_valid) begin
                        if (!stall) begin
                            instr_id_n   = skid_instr;
                            pc_plus_id_n = skid_pc_plus;
                            valid_id_n   = 1'b1;
                            skid_valid_n = 1'b0;
                        end
                    end else if (!stall) begin
                        instr_id_n = NOP_INSTR;
                        valid_id_n = 1'b0;
                    end
                end
                default: state_n = BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage
module tb_fetch_stage;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pcp;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [15:0] target;
    logic        stall;
    logic        ready;
    logic [15:0] instr_id;
    logic [15:0] pc_plus_id;
    logic        valid_id;

    int passed;
    int total;
    exp_t exp_q[$];

    fetch_stage_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus ();

    // Memory model: mem[a] = 16'hA000 + a, zero-wait when ready is high.
    assign bus.imem_data  = 16'hA000 + bus.imem_addr;
    assign bus.imem_ready = ready;

    fetch_stage dut (
        .clk                (clk),
        .rst                (rst),
        .branching_so_flush (flush),
        .branch_target      (target),
        .stall              (stall),
        .imem               (bus.master),
        .instr_id           (instr_id),
        .pc_plus_id         (pc_plus_id),
        .valid_id           (valid_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] instr, input logic [15:0] pcp);
        exp_t e;
        e.instr = instr;
        e.pcp   = pcp;
        exp_q.push_back(e);
    endtask

    // ID consumes IF/ID whenever it is valid and not stalled.
    always @(negedge clk) begin
        if (!rst && valid_id && !stall) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_instr got=%h pcp=%h exp=none at %0t", instr_id, pc_plus_id, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("mon_instr", {16'h0, instr_id}, {16'h0, e.instr});
                check("mon_pcplus", {16'h0, pc_plus_id}, {16'h0, e.pcp});
            end
        end
    end

    initial begin
        #100000;
        total++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        passed = 0;
        total  = 0;
        rst    = 1'b1;
        flush  = 1'b0;
        target = 16'h0;
        stall  = 1'b0;
        ready  = 1'b1;
        tick();
        tick();
        check("rst_req", {31'h0, bus.imem_req}, 32'h0);
        check("rst_valid", {31'h0, valid_id}, 32'h0);
        check("rst_instr", {16'h0, instr_id}, 32'h0);
        check("rst_pcplus", {16'h0, pc_plus_id}, 32'h0);
        check("rst_addr", {16'h0, bus.imem_addr}, 32'h0);

        rst = 1'b0;
        check("boot_req", {31'h0, bus.imem_req}, 32'h0);
        for (int i = 0; i < 5; i++) push(16'hA000 + 16'(i), 16'(i + 1));
        push(16'hA040, 16'h0041);
        push(16'hA080, 16'h0081);
        push(16'h9FFF, 16'h0000);
        push(16'hA000, 16'h0001);

        tick();
        check("fetch_req", {31'h0, bus.imem_req}, 32'h1);
        check("fetch_addr0", {16'h0, bus.imem_addr}, 32'h0);
        tick();
        check("first_instr", {16'h0, instr_id}, 32'hA000);
        check("first_valid", {31'h0, valid_id}, 32'h1);

        stall = 1'b1;
        tick();
        check("skid_req", {31'h0, bus.imem_req}, 32'h0);
        check("stall_hold", {16'h0, instr_id}, 32'hA000);
        tick();
        tick();
        check("skid_req_end", {31'h0, bus.imem_req}, 32'h0);
        check("stall_hold_end", {16'h0, instr_id}, 32'hA000);
        stall = 1'b0;
        tick();
        check("skid_out", {16'h0, instr_id}, 32'hA001);
        check("resume_req", {31'h0, bus.imem_req}, 32'h1);
        check("resume_addr", {16'h0, bus.imem_addr}, 32'h2);
        tick();
        tick();
        tick();

        flush  = 1'b1;
        target = 16'h0040;
        tick();
        flush = 1'b0;
        check("flush_valid", {31'h0, valid_id}, 32'h0);
        check("flush_addr", {16'h0, bus.imem_addr}, 32'h0040);
        tick();
        check("target_instr", {16'h0, instr_id}, 32'hA040);

        flush  = 1'b1;
        target = 16'h0005;
        tick();
        check("addr5", {16'h0, bus.imem_addr}, 32'h0005);
        flush  = 1'b1;
        target = 16'h0080;
        ready  = 1'b0;
        tick();
        flush = 1'b0;
        check("disc_addr_a", {16'h0, bus.imem_addr}, 32'h0005);
        check("disc_req", {31'h0, bus.imem_req}, 32'h1);
        check("disc_valid_a", {31'h0, valid_id}, 32'h0);
        tick();
        check("disc_addr_b", {16'h0, bus.imem_addr}, 32'h0005);
        ready = 1'b1;
        tick();
        check("disc_drop_valid", {31'h0, valid_id}, 32'h0);
        check("disc_redirect_addr", {16'h0, bus.imem_addr}, 32'h0080);
        tick();
        check("redirect_instr", {16'h0, instr_id}, 32'hA080);

        flush  = 1'b1;
        target = 16'hFFFF;
        tick();
        flush = 1'b0;
        check("wrap_addr", {16'h0, bus.imem_addr}, 32'hFFFF);
        tick();
        check("wrap_instr", {16'h0, instr_id}, 32'h9FFF);
        check("wrap_pcplus", {16'h0, pc_plus_id}, 32'h0000);
        check("wrap_next_addr", {16'h0, bus.imem_addr}, 32'h0000);
        tick();

        ready = 1'b0;
        tick();
        check("bubble_valid", {31'h0, valid_id}, 32'h0);
        check("bubble_addr", {16'h0, bus.imem_addr}, 32'h0001);
        flush  = 1'b1;
        target = 16'h0010;
        tick();
        flush = 1'b0;
        check("disc2_addr", {16'h0, bus.imem_addr}, 32'h0001);
        #2 rst = 1'b1;
        #1;
        check("rstdisc_req", {31'h0, bus.imem_req}, 32'h0);
        check("rstdisc_addr", {16'h0, bus.imem_addr}, 32'h0);
        check("rstdisc_valid", {31'h0, valid_id}, 32'h0);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        ready = 1'b1;
        check("rel1_req", {31'h0, bus.imem_req}, 32'h0);
        tick();
        check("rel1_addr", {16'h0, bus.imem_addr}, 32'h0);

        stall = 1'b1;
        tick();
        check("skid2_req", {31'h0, bus.imem_req}, 32'h0);
        check("skid2_valid", {31'h0, valid_id}, 32'h0);
        #2 rst = 1'b1;
        #1;
        check("rstskid_req", {31'h0, bus.imem_req}, 32'h0);
        check("rstskid_addr", {16'h0, bus.imem_addr}, 32'h0);
        check("rstskid_instr", {16'h0, instr_id}, 32'h0);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        stall = 1'b0;
        push(16'hA000, 16'h0001);
        tick();
        check("rel2_req", {31'h0, bus.imem_req}, 32'h1);
        check("rel2_addr", {16'h0, bus.imem_addr}, 32'h0);
        tick();
        check("rel2_instr", {16'h0, instr_id}, 32'hA000);
        @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
